// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch core.
//   state_e   : top-level FSM state
//   bcd_t     : one BCD digit
//   *W        : counter widths, sized for the largest supported rates
//   bcd_step  : +/-1 on a two-digit BCD field with wrap inside 0..max
package stopwatch_pkg;

  typedef enum logic [2:0] {StIdle, StRun, StPaused, StAdjust, StDone} state_e;

  typedef logic [3:0] bcd_t;

  // Widths cover a 100 MHz clock down to 1 Hz rates and a 1M-cycle debounce.
  localparam int unsigned MaxClkHz      = 100_000_000;
  localparam int unsigned MaxDebounce   = 1_000_000;
  localparam int unsigned PrescaleW     = $clog2(MaxClkHz);
  localparam int unsigned BlinkW        = $clog2(MaxClkHz);
  localparam int unsigned DebounceW     = $clog2(MaxDebounce);

  // Step a two-digit BCD value by one, wrapping within 0..max_v (no carry out).
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic down,
                                          input logic [7:0] max_v);
    bcd_t hi;
    bcd_t lo;
    logic [7:0] r;
    hi = v[7:4];
    lo = v[3:0];
    if (!down) begin
      if (v == max_v)      r = 8'h00;
      else if (lo == 4'd9) r = {hi + 4'd1, 4'd0};
      else                 r = {hi, lo + 4'd1};
    end else begin
      if (v == 8'h00)      r = max_v;
      else if (lo == 4'd0) r = {hi - 4'd1, 4'd9};
      else                 r = {hi, lo - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_button_debounce.sv
// Button conditioning: 2-FF synchroniser, stability counter, rising-edge pulse.
//   clk   : system clock
//   RESET : asynchronous active-high reset
//   btn   : raw, possibly bouncing button level
//   rise  : one-cycle pulse when the debounced level goes 0 -> 1
module button_debounce
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic RESET,
  input  logic btn,
  output logic rise
);

  logic                 sync1_q, sync2_q;
  logic                 level_q, level_dly_q;
  logic [DebounceW-1:0] cnt_q;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      rise        <= 1'b0;
    end else begin
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      level_dly_q <= level_q;
      rise        <= level_q & ~level_dly_q;
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DebounceW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + DebounceW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Single-clock mm:ss stopwatch with count up/down, adjust mode, lap hold and blink mask.
//   clk, RESET        : system clock, asynchronous active-high reset
//   btn_pause, btn_lap: raw buttons (debounced internally, rising edge acts)
//   dir               : 0 = up, 1 = down; sel: adjust field (0 = min, 1 = sec)
//   adj               : 1 = adjust mode (overrides all button edges)
//   digits            : BCD {m1,m0,s1,s0}; blank: per-digit blank, same order
//   running, done     : state indicators; lap_active: display frozen on snapshot
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned TICK_HZ         = 1,
  parameter int unsigned ADJ_HZ          = 2,
  parameter int unsigned BLINK_HZ        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_MIN         = 59
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        btn_pause,
  input  logic        btn_lap,
  input  logic        dir,
  input  logic        sel,
  input  logic        adj,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        running,
  output logic        done,
  output logic        lap_active
);

  localparam int unsigned TickDiv   = CLK_HZ / TICK_HZ;
  localparam int unsigned AdjDiv    = CLK_HZ / ADJ_HZ;
  localparam int unsigned BlinkDiv  = CLK_HZ / BLINK_HZ;
  localparam logic [7:0]  MaxMinBcd = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [7:0]  MaxSecBcd = 8'h59;

  logic pause_edge, lap_edge;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause_db (
    .clk   (clk),
    .RESET (RESET),
    .btn   (btn_pause),
    .rise  (pause_edge)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap_db (
    .clk   (clk),
    .RESET (RESET),
    .btn   (btn_lap),
    .rise  (lap_edge)
  );

  state_e               state_q, state_d;
  logic [PrescaleW-1:0] presc_q, presc_d, presc_limit;
  logic [BlinkW-1:0]    blink_q;
  logic                 phase_q;
  logic [7:0]           mm_q, mm_d, ss_q, ss_d;
  logic [15:0]          snap_q, snap_d;
  logic                 lap_q, lap_d;
  logic                 counting, tick, entering, is_zero;

  assign counting    = (state_q == StRun) || (state_q == StAdjust);
  assign presc_limit = (state_q == StAdjust) ? PrescaleW'(AdjDiv - 1) : PrescaleW'(TickDiv - 1);
  assign tick        = counting && (presc_q == presc_limit);
  assign is_zero     = (mm_q == 8'h00) && (ss_q == 8'h00);
  assign entering    = ((state_d == StRun) && (state_q != StRun)) ||
                       ((state_d == StAdjust) && (state_q != StAdjust));

  always_comb begin
    if (entering || !counting) presc_d = '0;
    else if (tick)             presc_d = '0;
    else                       presc_d = presc_q + PrescaleW'(1);
  end

  always_comb begin
    state_d = state_q;
    mm_d    = mm_q;
    ss_d    = ss_q;
    lap_d   = lap_q;
    snap_d  = snap_q;

    case (state_q)
      StIdle, StPaused: begin
        if (pause_edge) state_d = (dir && is_zero) ? StDone : StRun;
      end
      StRun: begin
        if (tick) begin
          if (!dir) begin
            ss_d = bcd_step(ss_q, 1'b0, MaxSecBcd);
            if (ss_q == MaxSecBcd) mm_d = bcd_step(mm_q, 1'b0, MaxMinBcd);
          end else if (is_zero) begin
            state_d = StDone;
          end else begin
            // Not at zero, so a seconds borrow always has a minute to take from.
            ss_d = bcd_step(ss_q, 1'b1, MaxSecBcd);
            if (ss_q == 8'h00) mm_d = bcd_step(mm_q, 1'b1, MaxMinBcd);
            if ((mm_d == 8'h00) && (ss_d == 8'h00)) state_d = StDone;
          end
        end
        if (pause_edge) state_d = StPaused;
      end
      StAdjust: begin
        if (tick) begin
          if (sel) ss_d = bcd_step(ss_q, dir, MaxSecBcd);
          else     mm_d = bcd_step(mm_q, dir, MaxMinBcd);
        end
        if (!adj) state_d = StPaused;
      end
      StDone: ;
      default: state_d = StIdle;
    endcase

    // Lap decision uses the state before this cycle's transition.
    if (lap_edge) begin
      if (state_q == StRun) begin
        lap_d = ~lap_q;
        if (!lap_q) snap_d = {mm_q, ss_q};
      end else begin
        lap_d = 1'b0;
      end
    end

    if (adj) begin
      state_d = StAdjust;
      lap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      presc_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      mm_q    <= 8'h00;
      ss_q    <= 8'h00;
      snap_q  <= 16'h0000;
      lap_q   <= 1'b0;
      digits  <= 16'h0000;
      blank   <= 4'b0000;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      snap_q  <= snap_d;
      lap_q   <= lap_d;
      if (blink_q == BlinkW'(BlinkDiv - 1)) begin
        blink_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        blink_q <= blink_q + BlinkW'(1);
      end
      digits  <= lap_q ? snap_q : {mm_q, ss_q};
      blank   <= ((state_q == StAdjust) && phase_q) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
      running <= (state_q == StRun);
      done    <= (state_q == StDone);
    end
  end

  assign lap_active = lap_q;

endmodule
